euro_sync_detect: RTL and testbench
===================================

# euro_sync_detect

Receive-side counterpart of the frame-sync Euro character. Watches a serial line for the 0x80 character, which appears as eight consecutive low bit periods (start bit plus seven zero data bits) followed by a high bit. On each valid detection it aligns a local flywheel frame counter to the remote frame generator. It produces a recovered 60 Hz frame strobe, a per-detection pulse and a lock indicator for the downstream frame logic.

## Interface
- `LOW_MIN`, 44: minimum accepted low-run length, in uart_clk ticks.
- `LOW_MAX`, 52: maximum accepted low-run length, in uart_clk ticks. Must be less than 63.
- `FRAME_TICKS`, 960: nominal frame period, in uart_clk ticks.
- `SYNC_OFFSET`, 48: frame-counter value loaded on a detection. This is the nominal pulse width, so detection is aligned to the remote frame start.
- `WINDOW`, 12: allowed ± deviation of a detection from `SYNC_OFFSET`.
- `LOCK_COUNT`, 3: number of consecutive in-window detections needed to lock.
- `MISS_LIMIT`, 4: number of consecutive missed frames that drop lock.
- `clk`  input  1  system clock. One clock domain.
- `rst_n`  input  1  asynchronous, active-low reset.
- `uart_clk`  input  1  one-`clk` enable at 6x the baud rate.
- `rx`  input  1  asynchronous serial input, idle high.
- `sync_pulse`  output  1  one-cycle pulse on each valid Euro detection.
- `enable_60hz`  output  1  one-cycle recovered frame strobe.
- `locked`  output  1  high while the flywheel is tracking the remote frame.

## Operation
- **Input synchronizer:** two flops, reset to 1. All logic below uses the synchronized `rx_s`.
- All counters advance only on `clk` cycles where `uart_clk=1`.
- **Low-run counter:** 6-bit, saturating at 63.
  - `rx_s=0`: increment.
  - `rx_s=1` with count ≠0: evaluate the run, then clear the counter.
  - The run is valid if `LOW_MIN` ≤ count ≤ `LOW_MAX`. Any other length (ordinary characters, a held break) is discarded silently.
- **Flywheel:** a frame counter of width $clog2(FRAME_TICKS).
  - Counts 0..FRAME_TICKS-1 and wraps to 0.
  - Emits a strobe at each wrap.
  - A valid detection loads the counter with `SYNC_OFFSET` and emits no strobe on that tick. Detection takes priority over a coincident wrap.
- **Window check:** a detection is in-window if the pre-load frame count lies in [SYNC_OFFSET-WINDOW, SYNC_OFFSET+WINDOW].
  - An in-window detection sets the `hit` flag. `hit` clears on every strobe.
- **Miss evaluation:** occurs on the tick where the frame count equals SYNC_OFFSET+WINDOW+1.
  - If `hit=0` and no detection occurs on that tick, `miss_cnt` increments, saturating at `MISS_LIMIT`.
  - If a detection occurs on that tick, it counts as out-of-window and the miss evaluation is suppressed.
- **Lock state machine:**
  - States are SEARCH (`locked=0`) and TRACK (`locked=1`).
  - `good_cnt` saturates at `LOCK_COUNT`.
  - In-window detection: `good_cnt`+1 and `miss_cnt`←0.
  - Out-of-window detection: `good_cnt`←0. In TRACK this also forces SEARCH.
  - SEARCH→TRACK when `good_cnt` reaches `LOCK_COUNT`.
  - TRACK→SEARCH when `miss_cnt` reaches `MISS_LIMIT`; `good_cnt` and `miss_cnt` are cleared.
  - Missed frames do not reset `good_cnt` in SEARCH unless `MISS_LIMIT` is reached.
- **Free-running behaviour:** after reset, before any detection, the flywheel runs free from 0. `enable_60hz` is therefore always present.

## Timing
- Reset values:
  - `sync_pulse`, `enable_60hz`, `locked`: 0.
  - All counters and `hit`: 0.
  - Synchronizer flops: 1.
- Reset is asynchronous and may arrive mid-run or mid-frame. It aborts everything; no partial state survives.
- `rx` to `rx_s` latency: 2 `clk` cycles.
- `sync_pulse`: asserted on the `clk` cycle after the `uart_clk` tick that samples the first high `rx_s` ending a valid run.
- `enable_60hz`: asserted on the `clk` cycle after the wrap tick.
- Both strobes are exactly one `clk` cycle wide and never coincide.
- `locked` changes on the `clk` cycle after the deciding tick.
- After a detection, the next strobe comes FRAME_TICKS-SYNC_OFFSET ticks later. Subsequent strobes are spaced every FRAME_TICKS ticks.

## Test plan
- **Reset and free run:** hold `rx=1` after reset release → `enable_60hz` on ticks 960, 1920, …; `sync_pulse=0`; `locked=0`.
- **Single Euro pulse:** `rx` low for 48 ticks, then high → one `sync_pulse`; next `enable_60hz` exactly 912 ticks after the detection tick.
- **Rejection:** low runs of 6, 30, 43, 53 and 200 ticks → no `sync_pulse`, flywheel phase unchanged. Runs of 44 and 52 ticks → accepted.
- **Lock acquisition:** Euro pulses every 960 ticks. The first is out-of-window (random phase) → `locked` rises after the 4th pulse, the 3rd in-window one. A pulse displaced by 20 ticks → `locked` falls immediately.
- **Flywheel holdover:** once locked, omit pulses → `enable_60hz` keeps 960-tick spacing; `locked` falls at the 4th miss evaluation. Omitting only 3 then resuming → `locked` stays 1.
- **Reset mid-operation:** assert `rst_n=0` 20 ticks into a low run while locked → all outputs 0 at once. The residual 28-tick low run after release → no `sync_pulse`.

Source files
------------

// File: rtl/euro_sync_detect.sv
// Euro (0x80) frame-sync detector: measures low runs on the serial line, aligns a
// flywheel frame counter to valid detections and tracks lock to the remote frame.
module euro_sync_detect #(
  parameter int unsigned LOW_MIN     = 44,
  parameter int unsigned LOW_MAX     = 52,
  parameter int unsigned FRAME_TICKS = 960,
  parameter int unsigned SYNC_OFFSET = 48,
  parameter int unsigned WINDOW      = 12,
  parameter int unsigned LOCK_COUNT  = 3,
  parameter int unsigned MISS_LIMIT  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic uart_clk,
  input  logic rx,
  output logic sync_pulse,
  output logic enable_60hz,
  output logic locked
);

  localparam int unsigned RW = 6;
  localparam int unsigned FW = $clog2(FRAME_TICKS);
  localparam int unsigned GW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned MW = $clog2(MISS_LIMIT + 1);

  localparam logic [RW-1:0] RUN_MIN    = RW'(LOW_MIN);
  localparam logic [RW-1:0] RUN_MAX    = RW'(LOW_MAX);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_TICKS - 1);
  localparam logic [FW-1:0] FRAME_LOAD = FW'(SYNC_OFFSET);
  localparam logic [FW-1:0] WIN_LO     = FW'(SYNC_OFFSET - WINDOW);
  localparam logic [FW-1:0] WIN_HI     = FW'(SYNC_OFFSET + WINDOW);
  localparam logic [FW-1:0] MISS_AT    = FW'(SYNC_OFFSET + WINDOW + 1);
  localparam logic [GW-1:0] GOOD_MAX   = GW'(LOCK_COUNT);
  localparam logic [MW-1:0] MISS_MAX   = MW'(MISS_LIMIT);

  localparam logic ST_SEARCH = 1'b0;
  localparam logic ST_TRACK  = 1'b1;

  logic          rx_meta_q, rx_meta_d;
  logic          rx_s_q, rx_s_d;
  logic [RW-1:0] run_q, run_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          hit_q, hit_d;
  logic [GW-1:0] good_q, good_d;
  logic [MW-1:0] miss_q, miss_d;
  logic          state_q, state_d;
  logic          sync_pulse_q, sync_pulse_d;
  logic          enable_60hz_q, enable_60hz_d;

  logic det_c, wrap_c, in_win_c, miss_eval_c;

  // Tick qualifiers: a detection overrides a coincident wrap and any miss evaluation.
  always_comb begin
    det_c       = uart_clk && rx_s_q && (run_q != '0) &&
                  (run_q >= RUN_MIN) && (run_q <= RUN_MAX);
    wrap_c      = uart_clk && !det_c && (frame_q == FRAME_LAST);
    in_win_c    = det_c && (frame_q >= WIN_LO) && (frame_q <= WIN_HI);
    miss_eval_c = uart_clk && !det_c && !hit_q && (frame_q == MISS_AT);
  end

  always_comb begin
    rx_meta_d     = rx;
    rx_s_d        = rx_meta_q;
    run_d         = run_q;
    frame_d       = frame_q;
    hit_d         = hit_q;
    good_d        = good_q;
    miss_d        = miss_q;
    state_d       = state_q;
    sync_pulse_d  = det_c;
    enable_60hz_d = wrap_c;

    if (uart_clk) begin
      if (!rx_s_q) begin
        run_d = (run_q == '1) ? run_q : run_q + RW'(1);
      end else begin
        run_d = '0;
      end

      if (det_c) begin
        frame_d = FRAME_LOAD;
      end else if (frame_q == FRAME_LAST) begin
        frame_d = '0;
      end else begin
        frame_d = frame_q + FW'(1);
      end
    end

    if (wrap_c) begin
      hit_d = 1'b0;
    end
    if (in_win_c) begin
      hit_d = 1'b1;
    end

    // Lock tracking: in-window hits build confidence, anything else erodes it.
    if (in_win_c) begin
      good_d = (good_q == GOOD_MAX) ? good_q : good_q + GW'(1);
      miss_d = '0;
      if (good_d == GOOD_MAX) begin
        state_d = ST_TRACK;
      end
    end else if (det_c) begin
      good_d  = '0;
      state_d = ST_SEARCH;
    end else if (miss_eval_c) begin
      miss_d = (miss_q == MISS_MAX) ? miss_q : miss_q + MW'(1);
      if (miss_d == MISS_MAX) begin
        state_d = ST_SEARCH;
        good_d  = '0;
        miss_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      run_q         <= '0;
      frame_q       <= '0;
      hit_q         <= 1'b0;
      good_q        <= '0;
      miss_q        <= '0;
      state_q       <= ST_SEARCH;
      sync_pulse_q  <= 1'b0;
      enable_60hz_q <= 1'b0;
    end else begin
      rx_meta_q     <= rx_meta_d;
      rx_s_q        <= rx_s_d;
      run_q         <= run_d;
      frame_q       <= frame_d;
      hit_q         <= hit_d;
      good_q        <= good_d;
      miss_q        <= miss_d;
      state_q       <= state_d;
      sync_pulse_q  <= sync_pulse_d;
      enable_60hz_q <= enable_60hz_d;
    end
  end

  assign sync_pulse  = sync_pulse_q;
  assign enable_60hz = enable_60hz_q;
  assign locked      = (state_q == ST_TRACK);

endmodule

// File: tb/tb_euro_sync_detect.sv
// Scoreboard bench for euro_sync_detect: expected (event, tick) pairs are queued by
// the stimulus and consumed by a monitor whenever a strobe appears.
module tb_euro_sync_detect;

  localparam int K_SYNC = 0;
  localparam int K_STB  = 1;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic uart_clk = 1'b0;
  logic rx       = 1'b1;
  logic sync_pulse, enable_60hz, locked;

  int unsigned tick_cnt;
  int          errors = 0;
  int          checks = 0;
  int          exp_q[$];
  int          mon_act, mon_exp;

  euro_sync_detect dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_clk   (uart_clk),
    .rx         (rx),
    .sync_pulse (sync_pulse),
    .enable_60hz(enable_60hz),
    .locked     (locked)
  );

  always #5 clk = ~clk;
  always @(negedge clk) uart_clk <= ~uart_clk;

  // Tick 1 is the first uart_clk tick after reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt <= 0;
    else if (uart_clk) tick_cnt <= tick_cnt + 1;
  end

  function automatic string kname(input int v);
    return (v % 2 == K_STB) ? "enable_60hz" : "sync_pulse";
  endfunction

  always @(negedge clk) begin
    if (rst_n && (sync_pulse || enable_60hz)) begin
      checks++;
      mon_act = int'(tick_cnt) * 2 + (enable_60hz ? K_STB : K_SYNC);
      if (sync_pulse && enable_60hz) begin
        errors++;
        $display("FAIL coincide: both strobes high at tick %0d, required at most one", tick_cnt);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected: got %s at tick %0d, required no event", kname(mon_act), tick_cnt);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act != mon_exp) begin
          errors++;
          $display("FAIL event: got %s at tick %0d, required %s at tick %0d",
                   kname(mon_act), mon_act / 2, kname(mon_exp), mon_exp / 2);
        end
      end
    end
  end

  initial begin
    #700000;
    $display("FAIL watchdog: simulation time limit reached at tick %0d", tick_cnt);
    $fatal(1, "watchdog");
  end

  task automatic expect_ev(input int kind, input int tick);
    exp_q.push_back(tick * 2 + kind);
  endtask

  task automatic wait_tick(input int unsigned n);
    while (tick_cnt < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b (tick %0d)", name, act, req, tick_cnt);
    end
  endtask

  task automatic check_lock(input string name, input int unsigned n, input logic req);
    wait_tick(n);
    check_bit(name, locked, req);
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected events still pending (first %s at tick %0d), required 0",
               name, exp_q.size(), kname(exp_q[0]), exp_q[0] / 2);
    end
  endtask

  // Low run of len ticks whose ending high sample lands on tick d (2 ticks of sync delay).
  task automatic euro_at(input int unsigned d, input int unsigned len);
    wait_tick(d - len - 2);
    rx = 1'b0;
    wait_tick(d - 2);
    rx = 1'b1;
  endtask

  initial begin
    // Reset and free run
    repeat (3) @(negedge clk);
    check_bit("rst_sync_pulse", sync_pulse, 1'b0);
    check_bit("rst_enable_60hz", enable_60hz, 1'b0);
    check_bit("rst_locked", locked, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_ev(K_STB, 960);
    expect_ev(K_STB, 1920);
    check_lock("freerun_locked", 1930, 1'b0);
    check_drained("freerun_drained");

    // Single Euro pulse, next strobe 912 ticks later
    expect_ev(K_SYNC, 2050);
    expect_ev(K_STB, 2962);
    euro_at(2050, 48);
    wait_tick(2990);
    check_drained("single_drained");

    // Rejected run lengths leave the phase alone; 44 and 52 are accepted
    expect_ev(K_STB, 3922);
    expect_ev(K_SYNC, 4046);
    expect_ev(K_STB, 4958);
    expect_ev(K_SYNC, 5054);
    expect_ev(K_STB, 5966);
    euro_at(3010, 6);
    euro_at(3060, 30);
    euro_at(3120, 43);
    euro_at(3200, 53);
    euro_at(3420, 200);
    euro_at(4046, 44);
    euro_at(5054, 52);
    check_lock("reject_locked", 5990, 1'b0);
    check_drained("reject_drained");

    // Lock acquisition: first pulse out of window, then three in window
    expect_ev(K_SYNC, 6100);
    expect_ev(K_STB, 7012);
    expect_ev(K_SYNC, 7060);
    expect_ev(K_STB, 7972);
    expect_ev(K_SYNC, 8020);
    expect_ev(K_STB, 8932);
    expect_ev(K_SYNC, 8980);
    expect_ev(K_STB, 9892);
    expect_ev(K_SYNC, 9960);
    expect_ev(K_STB, 10872);
    euro_at(6100, 48);
    euro_at(7060, 48);
    euro_at(8020, 48);
    check_lock("acq_two_good", 8020, 1'b0);
    euro_at(8980, 48);
    check_bit("acq_before_third", locked, 1'b0);
    check_lock("acq_locked", 8980, 1'b1);
    // Pulse displaced by 20 ticks
    euro_at(9960, 48);
    check_bit("displace_before", locked, 1'b1);
    check_lock("displace_unlock", 9960, 1'b0);

    // Relock, omit three pulses and resume, then omit four
    expect_ev(K_SYNC, 10920);
    expect_ev(K_STB, 11832);
    expect_ev(K_SYNC, 11880);
    expect_ev(K_STB, 12792);
    expect_ev(K_SYNC, 12840);
    expect_ev(K_STB, 13752);
    expect_ev(K_STB, 14712);
    expect_ev(K_STB, 15672);
    expect_ev(K_STB, 16632);
    expect_ev(K_SYNC, 16680);
    expect_ev(K_STB, 17592);
    expect_ev(K_STB, 18552);
    expect_ev(K_STB, 19512);
    expect_ev(K_STB, 20472);
    euro_at(10920, 48);
    euro_at(11880, 48);
    euro_at(12840, 48);
    check_lock("relock", 12840, 1'b1);
    check_lock("hold_three_miss", 15734, 1'b1);
    euro_at(16680, 48);
    check_lock("hold_resumed", 16700, 1'b1);
    check_lock("hold_third_miss", 20533, 1'b1);
    check_lock("hold_fourth_miss", 20534, 1'b0);
    check_drained("hold_drained");

    // Lock again, then reset 20 ticks into a low run
    expect_ev(K_STB, 21432);
    expect_ev(K_SYNC, 21480);
    expect_ev(K_STB, 22392);
    expect_ev(K_SYNC, 22440);
    expect_ev(K_STB, 23352);
    expect_ev(K_SYNC, 23400);
    euro_at(21480, 48);
    euro_at(22440, 48);
    euro_at(23400, 48);
    check_lock("prereset_locked", 23400, 1'b1);
    wait_tick(23500);
    check_drained("prereset_drained");
    rx = 1'b0;
    wait_tick(23520);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_bit("midrst_locked", locked, 1'b0);
    check_bit("midrst_sync_pulse", sync_pulse, 1'b0);
    check_bit("midrst_enable_60hz", enable_60hz, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    expect_ev(K_STB, 960);
    wait_tick(28);
    rx = 1'b1;
    check_lock("postrst_locked", 1000, 1'b0);
    check_drained("postrst_drained");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
